serial_word_loader: RTL and testbench

- Serial-in, parallel-out word assembler that sits directly upstream of the ring shift register stage.
- Collects WIDTH serial bits under a valid/ready handshake and presents each completed word on pdata with a valid/ready handshake. The downstream shift register uses that word as its load value.
- Flags dropped input bits with a sticky overflow.

---
 rtl/serial_word_loader_if.sv | 22 ++
 rtl/serial_word_loader.sv | 98 +++++++++
 tb/tb_serial_word_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_loader_if.sv
// Handshake bundle between a serial bit source, the word loader and the
// downstream parallel consumer (ring shift register load port).
interface serial_word_loader_if #(
  parameter int WIDTH = 4
) ();
  logic             sin;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;

  modport master (
    output sin, sin_valid, pready,
    input  sin_ready, pdata, pvalid
  );

  modport slave (
    input  sin, sin_valid, pready,
    output sin_ready, pdata, pvalid
  );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-in, parallel-out word assembler: collects WIDTH bits and hands the
// finished word downstream, flagging bits offered while it cannot accept.
//
// state   | meaning
// COLLECT | shifting serial bits into the assembly register
// HOLD    | completed word presented on pdata, waiting for pready
module serial_word_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_word_loader_if.slave      bus,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     ovf,
  input  logic                     clr_ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] asm_q, asm_nx, shifted;
  logic [WIDTH-1:0] pdata_q, pdata_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic             ovf_nx;
  logic             accept;

  assign bus.sin_ready = (state == COLLECT) || bus.pready;
  assign accept        = bus.sin_valid && bus.sin_ready;
  assign bus.pvalid    = (state == HOLD);
  assign bus.pdata     = pdata_q;
  assign bit_cnt       = cnt_q;

  always_comb begin
    if (MSB_FIRST) shifted = {asm_q[WIDTH-2:0], bus.sin};
    else           shifted = {bus.sin, asm_q[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    asm_nx   = asm_q;
    cnt_nx   = cnt_q;
    pdata_nx = pdata_q;
    case (state)
      COLLECT: begin
        if (accept) begin
          asm_nx = shifted;
          if (cnt_q == LAST_BIT) begin
            pdata_nx = shifted;
            cnt_nx   = '0;
            state_nx = HOLD;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.pready) begin
          state_nx = COLLECT;
          // Back-to-back: the bit accepted on the consume edge starts the next word.
          if (accept) begin
            asm_nx = shifted;
            cnt_nx = CW'(1);
          end
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    ovf_nx = ovf;
    if (bus.sin_valid && !bus.sin_ready) ovf_nx = 1'b1;
    else if (clr_ovf)                    ovf_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      asm_q   <= '0;
      cnt_q   <= '0;
      pdata_q <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      asm_q   <= asm_nx;
      cnt_q   <= cnt_nx;
      pdata_q <= pdata_nx;
      ovf     <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: MSB-first and LSB-first instances
// share one stimulus stream and are compared against a bit-list reference model.
module tb_serial_word_loader;
  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic d_sin = 1'b0, d_valid = 1'b0, d_pready = 1'b0, d_clr = 1'b0;

  serial_word_loader_if #(.WIDTH(W)) bus_m ();
  serial_word_loader_if #(.WIDTH(W)) bus_l ();

  assign bus_m.sin = d_sin;  assign bus_m.sin_valid = d_valid;  assign bus_m.pready = d_pready;
  assign bus_l.sin = d_sin;  assign bus_l.sin_valid = d_valid;  assign bus_l.pready = d_pready;

  logic [CW-1:0] cnt_m, cnt_l;
  logic          ovf_m, ovf_l;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(bus_m), .bit_cnt(cnt_m), .ovf(ovf_m), .clr_ovf(d_clr));
  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(bus_l), .bit_cnt(cnt_l), .ovf(ovf_l), .clr_ovf(d_clr));

  // Reference model: list of bits in the partial word, pending-word flag, last words.
  int m_bits[$];
  bit m_hold = 1'b0;
  int m_pm = 0, m_pl = 0;
  bit m_ovf = 1'b0;
  int q_m[$], q_l[$];
  int rise_cyc[$];
  int cyc = 0;
  int errors = 0, checks = 0;
  logic prev_m = 1'b0, prev_l = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_hold = 1'b0;
    m_pm = 0;
    m_pl = 0;
    m_ovf = 1'b0;
    q_m.delete();
    q_l.delete();
  endfunction

  function automatic void model_edge();
    bit rdy;
    int wm, wl;
    rdy = !m_hold || d_pready;
    if (m_hold && d_pready) m_hold = 1'b0;
    if (d_valid && rdy) begin
      m_bits.push_back(int'(d_sin));
      if (m_bits.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm += m_bits[i] << (W - 1 - i);
          wl += m_bits[i] << i;
        end
        m_pm = wm;
        m_pl = wl;
        q_m.push_back(wm);
        q_l.push_back(wl);
        m_bits.delete();
        m_hold = 1'b1;
      end
    end
    if (d_valid && !rdy) m_ovf = 1'b1;
    else if (d_clr)      m_ovf = 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) model_edge();
  end

  // Monitor: new words are popped on each pvalid rise; state compared every cycle.
  always @(negedge clk) begin
    if (bus_m.pvalid && !prev_m) begin
      rise_cyc.push_back(cyc);
      if (q_m.size() == 0) chk("word_msb_unexpected", 32'(bus_m.pdata), 32'hFFFF_FFFF);
      else                 chk("word_msb", 32'(bus_m.pdata), 32'(q_m.pop_front()));
    end
    if (bus_l.pvalid && !prev_l) begin
      if (q_l.size() == 0) chk("word_lsb_unexpected", 32'(bus_l.pdata), 32'hFFFF_FFFF);
      else                 chk("word_lsb", 32'(bus_l.pdata), 32'(q_l.pop_front()));
    end
    prev_m = bus_m.pvalid;
    prev_l = bus_l.pvalid;
    chk("pvalid_msb", 32'(bus_m.pvalid), 32'(m_hold));
    chk("pvalid_lsb", 32'(bus_l.pvalid), 32'(m_hold));
    chk("sin_ready_msb", 32'(bus_m.sin_ready), 32'(!m_hold || d_pready));
    chk("sin_ready_lsb", 32'(bus_l.sin_ready), 32'(!m_hold || d_pready));
    chk("bit_cnt_msb", 32'(cnt_m), 32'(m_bits.size()));
    chk("bit_cnt_lsb", 32'(cnt_l), 32'(m_bits.size()));
    chk("ovf_msb", 32'(ovf_m), 32'(m_ovf));
    chk("ovf_lsb", 32'(ovf_l), 32'(m_ovf));
    chk("pdata_msb", 32'(bus_m.pdata), 32'(m_pm));
    chk("pdata_lsb", 32'(bus_l.pdata), 32'(m_pl));
  end

  task automatic step(input bit s, input bit v, input bit p, input bit c);
    @(posedge clk);
    #1;
    d_sin = s; d_valid = v; d_pready = p; d_clr = c;
  endtask

  // Stream order: the word's leftmost bit is sent first.
  task automatic send_word(input int word, input bit p);
    for (int i = W - 1; i >= 0; i--) step(bit'((word >> i) & 1), 1'b1, p, 1'b0);
  endtask

  // Called just after a step; asserts reset mid-cycle and releases it mid-cycle.
  task automatic do_reset();
    d_valid = 1'b0;
    d_clr   = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_bit_cnt", 32'(cnt_m), 32'd0);
    chk("rst_pdata", 32'(bus_m.pdata), 32'd0);
    chk("rst_pvalid", 32'(bus_m.pvalid), 32'd0);
    chk("rst_ovf", 32'(ovf_m), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("init_pvalid", 32'(bus_m.pvalid), 32'd0);
    chk("init_sin_ready", 32'(bus_m.sin_ready), 32'd1);
    chk("init_bit_cnt", 32'(cnt_m), 32'd0);
    #20;
    rst = 1'b1;

    // MSB/LSB-first word with pready held high
    send_word('b1011, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp1_pvalid", 32'(bus_m.pvalid), 32'd1);
    chk("tp1_pdata_msb", 32'(bus_m.pdata), 32'hB);
    chk("tp1_pdata_lsb", 32'(bus_l.pdata), 32'hD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp1_pvalid_after", 32'(bus_m.pvalid), 32'd0);

    // Stalled downstream: drops set ovf, pdata frozen
    send_word('b1011, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp3_ovf", 32'(ovf_m), 32'd1);
    chk("tp3_pdata", 32'(bus_m.pdata), 32'hB);
    chk("tp3_sin_ready", 32'(bus_m.sin_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp3_ovf_clr", 32'(ovf_m), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp3_pvalid_released", 32'(bus_m.pvalid), 32'd0);

    // Back-to-back words, no bubble
    send_word('b1011, 1'b1);
    send_word('b0110, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    if (rise_cyc.size() >= 2)
      chk("tp4_spacing", 32'(rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2]), 32'(W));
    else
      chk("tp4_rises", 32'(rise_cyc.size()), 32'd2);
    chk("tp4_pdata", 32'(bus_m.pdata), 32'h6);
    chk("tp4_ovf", 32'(ovf_m), 32'd0);

    // Asynchronous reset with a partial word
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp5_partial_cnt", 32'(cnt_m), 32'd2);
    do_reset();
    send_word('b0110, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp5_pdata_msb", 32'(bus_m.pdata), 32'h6);
    chk("tp5_pdata_lsb", 32'(bus_l.pdata), 32'h6);

    // Drop and clr_ovf on the same edge: set wins
    send_word('b1001, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp6_ovf_set_wins", 32'(ovf_m), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(bit'($urandom_range(1)), ($urandom_range(3) != 0),
           ($urandom_range(2) != 0), ($urandom_range(15) == 0));
      if ($urandom_range(299) == 0) do_reset();
    end

    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("queues_drained", 32'(q_m.size() + q_l.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
